relu_maxpool2x2_stream: RTL and testbench

Streaming ReLU plus 2x2/stride-2 max-pool stage that sits directly downstream of a conv2d featuremap filter block. It consumes one IEEE-754 single-precision pixel per valid cycle in raster order from the filter's `data_out`/`valid_out`. It emits one pooled, rectified value per 2x2 window, also in raster order, to the next layer's input FIFO. One instance serves one output channel.

---
 rtl/relu_maxpool2x2_stream_pkg.sv | 16 +
 rtl/pool_line_buffer.sv | 24 ++
 rtl/relu_maxpool2x2_stream.sv | 97 +++++++++
 tb/tb_relu_maxpool2x2_stream.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/relu_maxpool2x2_stream_pkg.sv
// Shared CNN helpers for fp32 feature-map post-processing.
// Rectified values are non-negative, so their bit patterns order like unsigned integers.
package relu_maxpool2x2_stream_pkg;

  localparam int          FP32_SIGN_BIT = 31;
  localparam logic [31:0] FP32_ZERO     = 32'h0;

  function automatic logic [31:0] relu_fp32(input logic [31:0] x);
    return x[FP32_SIGN_BIT] ? FP32_ZERO : x;
  endfunction

  function automatic logic [31:0] max_pos_fp32(input logic [31:0] a, input logic [31:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pool_line_buffer.sv
// Single-row buffer of horizontal pair maxima.
// Combinational read; contents are not reset because every entry is written before it is read.
module pool_line_buffer #(
  parameter int DEPTH      = 28,
  parameter int DATA_WIDTH = 32,
  parameter int AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/relu_maxpool2x2_stream.sv
// Streaming ReLU followed by 2x2/stride-2 max-pool over a raster-order fp32 feature map.
// Even rows park pair maxima in the line buffer; odd rows combine with them and emit.
module relu_maxpool2x2_stream
  import relu_maxpool2x2_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int WIDTH      = 56,
  parameter int HEIGHT     = 56
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  valid_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  frame_done
);

  localparam int CW = $clog2(WIDTH);
  localparam int RW = (HEIGHT > 2) ? $clog2(HEIGHT) : 1;
  localparam int AW = CW - 1;

  logic [CW-1:0]         col_q, col_d;
  logic [RW-1:0]         row_q, row_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  valid_q, valid_d;
  logic                  done_q, done_d;

  logic [DATA_WIDTH-1:0] px, hmax, lb_rdata;
  logic                  last_col, last_row, lb_we;
  logic [AW-1:0]         lb_addr;

  always_comb begin
    px       = relu_fp32(data_in);
    hmax     = max_pos_fp32(hold_q, px);
    last_col = (col_q == CW'(WIDTH - 1));
    last_row = (row_q == RW'(HEIGHT - 1));
    lb_addr  = col_q[CW-1:1];
    lb_we    = valid_in & col_q[0] & ~row_q[0];

    col_d      = col_q;
    row_d      = row_q;
    hold_d     = hold_q;
    valid_d    = 1'b0;
    done_d     = 1'b0;
    data_out_d = data_out_q;

    if (valid_in) begin
      col_d = last_col ? '0 : col_q + CW'(1);
      if (last_col) row_d = last_row ? '0 : row_q + RW'(1);
      if (!col_q[0]) hold_d = px;
      // Odd row, odd col closes a 2x2 window.
      if (col_q[0] && row_q[0]) begin
        valid_d    = 1'b1;
        done_d     = last_col & last_row;
        data_out_d = max_pos_fp32(lb_rdata, hmax);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q      <= '0;
      row_q      <= '0;
      hold_q     <= '0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      col_q      <= col_d;
      row_q      <= row_d;
      hold_q     <= hold_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      done_q     <= done_d;
    end
  end

  pool_line_buffer #(
    .DEPTH      (WIDTH / 2),
    .DATA_WIDTH (DATA_WIDTH),
    .AW         (AW)
  ) u_linebuf (
    .clk   (clk),
    .we    (lb_we),
    .waddr (lb_addr),
    .wdata (hmax),
    .raddr (lb_addr),
    .rdata (lb_rdata)
  );

  assign data_out   = data_out_q;
  assign valid_out  = valid_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_relu_maxpool2x2_stream.sv
// Bench for relu_maxpool2x2_stream: a 4x2 instance for the hand-worked cases and a 56x56
// instance for randomized frames, both checked cycle by cycle against a window-max model.
module tb_relu_maxpool2x2_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] s_din, b_din, s_dout, b_dout;
  logic        s_vin, b_vin, s_vout, b_vout, s_fd, b_fd;

  int checks   = 0;
  int failures = 0;

  logic [31:0] frame [56*56];
  logic [31:0] held [2];
  logic [31:0] got_q [$];

  always #5 clk = ~clk;

  relu_maxpool2x2_stream #(.DATA_WIDTH(32), .WIDTH(4), .HEIGHT(2)) u_small (
    .clk(clk), .rst(rst), .data_in(s_din), .valid_in(s_vin),
    .data_out(s_dout), .valid_out(s_vout), .frame_done(s_fd));

  relu_maxpool2x2_stream #(.DATA_WIDTH(32), .WIDTH(56), .HEIGHT(56)) u_big (
    .clk(clk), .rst(rst), .data_in(b_din), .valid_in(b_vin),
    .data_out(b_dout), .valid_out(b_vout), .frame_done(b_fd));

  function automatic logic [31:0] ref_relu(input logic [31:0] x);
    return x[31] ? 32'h0 : x;
  endfunction

  function automatic logic [31:0] ref_max(input logic [31:0] a, input logic [31:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [31:0] rand_px();
    logic [31:0] v;
    v = {1'($urandom_range(0, 1)), 8'($urandom_range(0, 254)), 23'($urandom)};
    return v;
  endfunction

  task automatic tick(input bit big, input logic [31:0] px, input bit v,
                      output logic vo, output logic [31:0] dout, output logic fd);
    if (big) begin b_din = px; b_vin = v; end
    else     begin s_din = px; s_vin = v; end
    @(posedge clk);
    #1;
    vo   = big ? b_vout : s_vout;
    dout = big ? b_dout : s_dout;
    fd   = big ? b_fd   : s_fd;
    s_vin = 1'b0;
    b_vin = 1'b0;
  endtask

  // Sends frame[0 .. w*h-1]; every cycle is checked, each strobe must follow its closing pixel.
  task automatic send_frame(input bit big, input int w, input int h, input int stall_pct,
                            output int n_out, output int n_done);
    logic [31:0] expw [784];
    logic        vo, fd;
    logic [31:0] dout;
    int          bi;
    bi = big ? 1 : 0;
    for (int r = 0; r < h / 2; r++)
      for (int c = 0; c < w / 2; c++)
        expw[r * (w / 2) + c] = ref_max(
          ref_max(ref_relu(frame[(2*r)*w + 2*c]),   ref_relu(frame[(2*r)*w + 2*c + 1])),
          ref_max(ref_relu(frame[(2*r+1)*w + 2*c]), ref_relu(frame[(2*r+1)*w + 2*c + 1])));
    got_q.delete();
    n_out  = 0;
    n_done = 0;
    for (int i = 0; i < w * h; i++) begin
      int  row, col, k;
      bit  ev;
      while (stall_pct > 0 && $urandom_range(0, 99) < stall_pct) begin
        tick(big, rand_px(), 1'b0, vo, dout, fd);
        checks++;
        if (vo !== 1'b0 || fd !== 1'b0 || dout !== held[bi]) begin
          failures++;
          $display("FAIL stall_idle px=%0d valid=%b done=%b data=%h required valid=0 done=0 data=%h",
                   i, vo, fd, dout, held[bi]);
        end
      end
      tick(big, frame[i], 1'b1, vo, dout, fd);
      row = i / w;
      col = i % w;
      ev  = (row % 2 == 1) && (col % 2 == 1);
      k   = (row / 2) * (w / 2) + col / 2;
      if (ev) held[bi] = expw[k];
      if (vo === 1'b1) begin n_out++; got_q.push_back(dout); end
      if (fd === 1'b1) n_done++;
      checks++;
      if (vo !== ev) begin
        failures++;
        $display("FAIL valid_out px=%0d (r%0d,c%0d) got=%b required=%b", i, row, col, vo, ev);
      end
      checks++;
      if (dout !== held[bi]) begin
        failures++;
        $display("FAIL data_out px=%0d (r%0d,c%0d) got=%h required=%h", i, row, col, dout, held[bi]);
      end
      checks++;
      if (fd !== (ev && i == w * h - 1)) begin
        failures++;
        $display("FAIL frame_done px=%0d got=%b required=%b", i, fd, (ev && i == w * h - 1));
      end
    end
  endtask

  task automatic load_basic();
    logic [31:0] b [8];
    b = '{32'h3F800000, 32'h40000000, 32'h3F000000, 32'h40400000,
          32'h3E800000, 32'h40800000, 32'h3FC00000, 32'h00000000};
    for (int i = 0; i < 8; i++) frame[i] = b[i];
  endtask

  task automatic check_basic_outputs(input string tag, input int n_out, input int n_done);
    checks++;
    if (n_out != 2 || got_q.size() != 2) begin
      failures++;
      $display("FAIL %s_count got=%0d required=2", tag, n_out);
    end else begin
      checks++;
      if (got_q[0] !== 32'h40800000 || got_q[1] !== 32'h40400000) begin
        failures++;
        $display("FAIL %s_values got=%h,%h required=40800000,40400000", tag, got_q[0], got_q[1]);
      end
    end
    checks++;
    if (n_done != 1) begin
      failures++;
      $display("FAIL %s_done_count got=%0d required=1", tag, n_done);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    checks++;
    if (s_vout !== 1'b0 || s_fd !== 1'b0 || s_dout !== 32'h0 ||
        b_vout !== 1'b0 || b_fd !== 1'b0 || b_dout !== 32'h0) begin
      failures++;
      $display("FAIL %s small v/d/data=%b/%b/%h big v/d/data=%b/%b/%h required all zero",
               tag, s_vout, s_fd, s_dout, b_vout, b_fd, b_dout);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("reset_during");
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_zero_outputs("reset_after");
    held[0] = 32'h0;
    held[1] = 32'h0;
  endtask

  task automatic test_basic_pool();
    int n_out, n_done;
    load_basic();
    send_frame(1'b0, 4, 2, 0, n_out, n_done);
    check_basic_outputs("basic", n_out, n_done);
  endtask

  task automatic test_all_negative();
    int n_out, n_done;
    logic [31:0] b [8];
    b = '{32'hBF800000, 32'hC0000000, 32'h3F800000, 32'h80000000,
          32'h80000000, 32'hC0400000, 32'h40A00000, 32'hBF000000};
    for (int i = 0; i < 8; i++) frame[i] = b[i];
    send_frame(1'b0, 4, 2, 0, n_out, n_done);
    checks++;
    if (got_q.size() != 2 || got_q[0] !== 32'h0 || got_q[1] !== 32'h40A00000) begin
      failures++;
      $display("FAIL all_negative got_n=%0d first=%h required first=00000000 second=40a00000",
               got_q.size(), (got_q.size() > 0) ? got_q[0] : 32'hx);
    end
  endtask

  task automatic test_stall();
    int n_out, n_done;
    for (int rep = 0; rep < 4; rep++) begin
      load_basic();
      send_frame(1'b0, 4, 2, 50, n_out, n_done);
      check_basic_outputs("stall", n_out, n_done);
    end
  endtask

  task automatic test_back_to_back();
    int n_out, n_done, total_done;
    total_done = 0;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 56 * 56; i++) frame[i] = rand_px();
      send_frame(1'b1, 56, 56, 0, n_out, n_done);
      total_done += n_done;
      checks++;
      if (n_out != 784) begin
        failures++;
        $display("FAIL b2b_count frame=%0d got=%0d required=784", f, n_out);
      end
    end
    checks++;
    if (total_done != 2) begin
      failures++;
      $display("FAIL b2b_done_pulses got=%0d required=2", total_done);
    end
  endtask

  task automatic test_reset_mid_frame();
    int n_out, n_done;
    logic vo, fd;
    logic [31:0] dout;
    for (int i = 0; i < 3; i++) tick(1'b0, rand_px(), 1'b1, vo, dout, fd);
    for (int i = 0; i < 30; i++) tick(1'b1, rand_px(), 1'b1, vo, dout, fd);
    #2;
    rst = 1'b1;
    #1;
    check_zero_outputs("reset_mid_async");
    @(posedge clk);
    #2;
    rst = 1'b0;
    held[0] = 32'h0;
    held[1] = 32'h0;
    load_basic();
    send_frame(1'b0, 4, 2, 0, n_out, n_done);
    check_basic_outputs("reset_mid_small", n_out, n_done);
    for (int i = 0; i < 56 * 56; i++) frame[i] = rand_px();
    send_frame(1'b1, 56, 56, 20, n_out, n_done);
    checks++;
    if (n_out != 784 || n_done != 1) begin
      failures++;
      $display("FAIL reset_mid_big outputs=%0d dones=%0d required 784 and 1", n_out, n_done);
    end
  endtask

  initial begin
    rst   = 1'b1;
    s_din = '0;
    b_din = '0;
    s_vin = 1'b0;
    b_vin = 1'b0;
    test_reset();
    test_basic_pool();
    test_all_negative();
    test_stall();
    test_back_to_back();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
